// File: rtl/in_channel_ctrl.sv
// Input-channel controller: a producer fills a small word buffer (LOAD), then the
// CPU reads it back through an inSize/in request port with one-cycle responses (SERVE).
module in_channel_ctrl #(
    parameter int unsigned MemoryElementWidth = 12,
    parameter int unsigned NIn                = 2
) (
    input  logic                         clock,
    input  logic                         run,
    input  logic                         load_valid,
    input  logic [MemoryElementWidth-1:0] load_data,
    output logic                         load_ready,
    input  logic                         load_last,
    input  logic                         reload,
    input  logic                         req_valid,
    input  logic                         req_op,
    output logic                         req_ready,
    output logic                         resp_valid,
    output logic [MemoryElementWidth-1:0] resp_data,
    output logic                         resp_empty,
    output logic                         loaded,
    output logic [$clog2(NIn+1)-1:0]     count
);
    localparam int unsigned W  = MemoryElementWidth;
    localparam int unsigned CW = $clog2(NIn + 1);
    localparam int unsigned AW = (NIn > 1) ? $clog2(NIn) : 1;

    typedef enum logic {LOAD, SERVE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  rdptr_q, rdptr_d;
    logic [W-1:0]   mem [NIn];
    logic           resp_valid_d;
    logic [W-1:0]   resp_data_d;
    logic           resp_empty_d;
    logic           load_hs;
    logic           req_hs;

    // Handshake qualifiers are gated by run so nothing is offered during reset.
    assign load_ready = run && (state_q == LOAD) && (count_q < CW'(NIn));
    assign req_ready  = run && (state_q == SERVE) && !reload;
    assign load_hs    = load_valid && load_ready;
    assign req_hs     = req_valid && req_ready;
    assign loaded     = (state_q == SERVE);
    assign count      = count_q;

    always_ff @(posedge clock or negedge run) begin
        if (!run) begin
            state_q    <= LOAD;
            count_q    <= '0;
            rdptr_q    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_empty <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rdptr_q    <= rdptr_d;
            resp_valid <= resp_valid_d;
            resp_data  <= resp_data_d;
            resp_empty <= resp_empty_d;
        end
    end

    // Buffer storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clock) begin
        if (load_hs) begin
            mem[AW'(count_q)] <= load_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rdptr_d      = rdptr_q;
        resp_valid_d = 1'b0;
        resp_data_d  = '0;
        resp_empty_d = 1'b0;
        case (state_q)
            LOAD: begin
                if (reload) begin
                    count_d = '0;
                    rdptr_d = '0;
                end else begin
                    if (load_hs) begin
                        count_d = count_q + CW'(1);
                    end
                    // Filling the last slot closes the load phase on its own.
                    if (load_last || (load_hs && (count_q == CW'(NIn - 1)))) begin
                        state_d = SERVE;
                    end
                end
            end
            SERVE: begin
                if (reload) begin
                    count_d = '0;
                    rdptr_d = '0;
                    state_d = LOAD;
                end else if (req_hs) begin
                    resp_valid_d = 1'b1;
                    if (!req_op) begin
                        resp_data_d = W'(count_q - rdptr_q);
                    end else if (rdptr_q < count_q) begin
                        resp_data_d = mem[AW'(rdptr_q)];
                        rdptr_d     = rdptr_q + CW'(1);
                    end else begin
                        resp_empty_d = 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end
endmodule
